bdc_root: RTL and testbench



---
 rtl/bdc_root_pkg.sv | 40 ++++
 rtl/bdc_root_if.sv | 14 +
 rtl/bdc_motor_chan.sv | 92 +++++++++
 rtl/bdc_root.sv | 190 +++++++++++++++++++
 tb/tb_bdc_root.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bdc_root_pkg.sv
// Shared constants and types for the brushed DC motor controller: register map,
// WDCTL bit positions, watchdog prescaler terminal counts and the SPI FSM states.
package bdc_root_pkg;

  localparam int         NUM_CH    = 3;
  localparam logic [7:0] HWCFG_VAL = 8'h30;

  localparam logic [3:0] A_HWCFG = 4'hD;
  localparam logic [3:0] A_WDDIV = 4'hE;
  localparam logic [3:0] A_WDCTL = 4'hF;

  localparam logic [1:0] CH_DUTY = 2'd0;
  localparam logic [1:0] CH_TACH = 2'd1;
  localparam logic [1:0] CH_CFG  = 2'd2;

  localparam int CFG_REV   = 0;
  localparam int CFG_BRAKE = 1;
  localparam int CFG_TINV  = 2;

  localparam int WD_TRIP    = 7;
  localparam int WD_MOTOREN = 3;

  localparam logic [7:0] WDDIV_RST = 8'hFF;

  localparam int          PRE_W       = 16;
  localparam logic [5:0]  PRE_FAST_TC = 6'h3F;
  localparam logic [15:0] PRE_SLOW_TC = 16'hFFFF;

  typedef enum logic [1:0] {
    SPI_CMD  = 2'd0,
    SPI_DATA = 2'd1,
    SPI_DONE = 2'd2
  } spi_st_e;

  // Position of a quadrature state along the forward sequence 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/bdc_root_if.sv
// SPI slave port bundle; miso_pin is the tri-stated pad view of miso.
interface bdc_root_if;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;
  logic miso_oe;
  wire  miso_pin;

  assign miso_pin = miso_oe ? miso : 1'bz;

  modport slave  (input sclk, ss, mosi, output miso, miso_oe);
  modport master (output sclk, ss, mosi, input miso, miso_oe, miso_pin);
endinterface

// File: rtl/bdc_motor_chan.sv
// One motor channel: DUTY/CFG registers, quadrature tach counter and
// PWM compare with enable/overcurrent gating.
module bdc_motor_chan
  import bdc_root_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_sel,
  input  logic [7:0] i_wr_data,
  input  logic [1:0] i_rd_sel,
  output logic [7:0] o_rd_data,
  input  logic [7:0] i_pwm_cnt,
  input  logic       i_pwm_wrap,
  input  logic       i_enable,
  input  logic [1:0] i_tach,
  input  logic       i_currentlimit,
  output logic [1:0] o_pwm
);

  logic [1:0] r_tach_q1, r_tach_q2, r_tach_prev;
  logic       r_cl_q1, r_cl_q2, r_oc_hold;
  logic [7:0] r_duty, r_duty_act, r_cfg, r_tach_cnt;

  logic [1:0] w_step;
  logic       w_up, w_dn, w_oc, w_active;
  logic [1:0] w_drive;

  // +1 step forward, 3 (= -1) step reverse, 2 is an illegal double-bit change.
  assign w_step = gray_pos(r_tach_q2) - gray_pos(r_tach_prev);
  assign w_up   = r_cfg[CFG_TINV] ? (w_step == 2'd3) : (w_step == 2'd1);
  assign w_dn   = r_cfg[CFG_TINV] ? (w_step == 2'd1) : (w_step == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tach_q1   <= '0;
      r_tach_q2   <= '0;
      r_tach_prev <= '0;
      r_cl_q1     <= 1'b0;
      r_cl_q2     <= 1'b0;
      r_oc_hold   <= 1'b0;
      r_duty      <= '0;
      r_duty_act  <= '0;
      r_cfg       <= '0;
      r_tach_cnt  <= '0;
    end else begin
      r_tach_q1   <= i_tach;
      r_tach_q2   <= r_tach_q1;
      r_tach_prev <= r_tach_q2;
      r_cl_q1     <= i_currentlimit;
      r_cl_q2     <= r_cl_q1;

      if (w_up)      r_tach_cnt <= r_tach_cnt + 8'd1;
      else if (w_dn) r_tach_cnt <= r_tach_cnt - 8'd1;

      // Overcurrent blanks the rest of the PWM period it was seen in.
      if (i_pwm_wrap)   r_oc_hold <= r_cl_q2;
      else if (r_cl_q2) r_oc_hold <= 1'b1;

      if (i_pwm_wrap) r_duty_act <= r_duty;

      if (i_wr_en) begin
        case (i_wr_sel)
          CH_DUTY: r_duty <= i_wr_data;
          CH_CFG:  r_cfg  <= i_wr_data;
          default: ;
        endcase
      end
    end
  end

  assign w_oc     = r_cl_q2 | r_oc_hold;
  assign w_active = i_pwm_cnt < r_duty_act;

  always_comb begin
    w_drive = 2'b00;
    if (r_cfg[CFG_BRAKE])   w_drive = 2'b11;
    else if (w_active)      w_drive = r_cfg[CFG_REV] ? 2'b10 : 2'b01;
    o_pwm = (i_enable && !w_oc) ? w_drive : 2'b00;
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_sel)
      CH_DUTY: o_rd_data = r_duty;
      CH_TACH: o_rd_data = r_tach_cnt;
      CH_CFG:  o_rd_data = r_cfg;
      default: ;
    endcase
  end

endmodule

// File: rtl/bdc_root.sv
// Three-channel brushed DC motor controller: SPI register slave, watchdog,
// shared PWM counter and register read mux around three bdc_motor_chan lanes.
module bdc_root
  import bdc_root_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  bdc_root_if.slave  spi,
  input  logic       tstn,
  input  logic       wdogdisn,
  input  logic       currentlimit0,
  input  logic       currentlimit1,
  input  logic       currentlimit2,
  input  logic [1:0] tach0,
  input  logic [1:0] tach1,
  input  logic [1:0] tach2,
  output logic       motorena,
  output logic [1:0] pwm0,
  output logic [1:0] pwm1,
  output logic [1:0] pwm2
);

  logic [1:0] r_sclk_q, r_ss_q, r_mosi_q;
  logic       r_sclk_d;
  logic       w_sclk_s, w_ss_s, w_mosi_s, w_rise;

  spi_st_e    r_st, w_st_nxt;
  logic [2:0] r_bit;
  logic [6:0] r_rx;
  logic       r_rw;
  logic [3:0] r_addr;
  logic [7:0] r_tx;
  logic       w_cmd_done, w_xfer_done, w_wr_en;
  logic [7:0] w_wr_data, w_rd_data;
  logic [3:0] w_rd_addr;

  logic [7:0]       r_wddiv, r_wdcnt, r_pwm_cnt;
  logic [3:0]       r_wdctl;
  logic             r_trip;
  logic [PRE_W-1:0] r_pre;
  logic             w_wd_run, w_wd_tick, w_trip_clr, w_pwm_wrap;

  logic [NUM_CH-1:0]            w_ch_we, w_ch_en, w_ch_cl;
  logic [NUM_CH-1:0][1:0]       w_ch_tach, w_ch_pwm;
  logic [NUM_CH-1:0][7:0]       w_ch_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_q <= 2'b11;
      r_sclk_d <= 1'b1;
      r_ss_q   <= 2'b00;
      r_mosi_q <= 2'b00;
    end else begin
      r_sclk_q <= {r_sclk_q[0], spi.sclk};
      r_sclk_d <= r_sclk_q[1];
      r_ss_q   <= {r_ss_q[0], spi.ss};
      r_mosi_q <= {r_mosi_q[0], spi.mosi};
    end
  end

  assign w_sclk_s = r_sclk_q[1];
  assign w_ss_s   = r_ss_q[1];
  assign w_mosi_s = r_mosi_q[1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= SPI_CMD;
    else       r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cmd_done  = 1'b0;
    w_xfer_done = 1'b0;
    if (!w_ss_s) begin
      w_st_nxt = SPI_CMD;
    end else if (w_rise && r_bit == 3'd7) begin
      case (r_st)
        SPI_CMD:  begin w_st_nxt = SPI_DATA; w_cmd_done  = 1'b1; end
        SPI_DATA: begin w_st_nxt = SPI_DONE; w_xfer_done = 1'b1; end
        default:  ;
      endcase
    end
  end

  // Command byte is {rw, addr[3:0], 3'b000}; r_rx holds its first 7 bits at rise 8.
  assign w_rd_addr = r_rx[5:2];
  assign w_wr_data = {r_rx, w_mosi_s};
  assign w_wr_en   = w_xfer_done & ~r_rw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit  <= '0;
      r_rx   <= '0;
      r_rw   <= 1'b0;
      r_addr <= '0;
      r_tx   <= 8'hFF;
    end else if (!w_ss_s) begin
      r_bit <= '0;
      r_tx  <= 8'hFF;
    end else if (w_rise && r_st != SPI_DONE) begin
      r_bit <= r_bit + 3'd1;
      r_rx  <= {r_rx[5:0], w_mosi_s};
      if (w_cmd_done) begin
        r_rw   <= r_rx[6];
        r_addr <= w_rd_addr;
        r_tx   <= w_rd_data;
      end else if (r_st == SPI_DATA) begin
        r_tx <= {r_tx[6:0], 1'b1};
      end
    end
  end

  assign spi.miso    = r_tx[7];
  assign spi.miso_oe = w_ss_s;

  always_comb begin
    w_rd_data = '0;
    case (w_rd_addr)
      A_HWCFG: w_rd_data = HWCFG_VAL;
      A_WDDIV: w_rd_data = r_wddiv;
      A_WDCTL: w_rd_data = {r_trip, 3'b000, r_wdctl};
      default: if (w_rd_addr[3:2] != 2'b11) w_rd_data = w_ch_rd[w_rd_addr[3:2]];
    endcase
  end

  assign w_wd_run   = r_wdctl[WD_MOTOREN] & ~r_trip & wdogdisn;
  assign w_wd_tick  = w_wd_run & (tstn ? (r_pre == PRE_SLOW_TC) : (r_pre[5:0] == PRE_FAST_TC));
  assign w_trip_clr = w_wr_en && (r_addr == A_WDCTL) && w_wr_data[WD_TRIP];
  assign w_pwm_wrap = &r_pwm_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wddiv   <= WDDIV_RST;
      r_wdctl   <= '0;
      r_trip    <= 1'b0;
      r_pre     <= '0;
      r_wdcnt   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;

      if (w_wr_en && r_addr == A_WDDIV) r_wddiv <= w_wr_data;
      if (w_wr_en && r_addr == A_WDCTL) r_wdctl <= w_wr_data[3:0];

      if (!w_wd_run) r_pre <= '0;
      else           r_pre <= r_pre + 1'b1;

      // A kick in the terminal-count cycle still saves the motors.
      if (!w_wd_run || w_xfer_done) r_wdcnt <= '0;
      else if (w_wd_tick)           r_wdcnt <= r_wdcnt + 8'd1;

      if (w_trip_clr)
        r_trip <= 1'b0;
      else if (w_wd_tick && !w_xfer_done && r_wdcnt == r_wddiv)
        r_trip <= 1'b1;
    end
  end

  assign motorena = r_wdctl[WD_MOTOREN] & ~r_trip;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_we[g] = w_wr_en && (r_addr[3:2] == 2'(g));
    assign w_ch_en[g] = motorena & r_wdctl[g];
  end

  assign w_ch_tach = {tach2, tach1, tach0};
  assign w_ch_cl   = {currentlimit2, currentlimit1, currentlimit0};

  bdc_motor_chan u_chan [NUM_CH-1:0] (
    .clk            (clk),
    .rstn           (rstn),
    .i_wr_en        (w_ch_we),
    .i_wr_sel       (r_addr[1:0]),
    .i_wr_data      (w_wr_data),
    .i_rd_sel       (w_rd_addr[1:0]),
    .o_rd_data      (w_ch_rd),
    .i_pwm_cnt      (r_pwm_cnt),
    .i_pwm_wrap     (w_pwm_wrap),
    .i_enable       (w_ch_en),
    .i_tach         (w_ch_tach),
    .i_currentlimit (w_ch_cl),
    .o_pwm          (w_ch_pwm)
  );

  assign pwm0 = w_ch_pwm[0];
  assign pwm1 = w_ch_pwm[1];
  assign pwm2 = w_ch_pwm[2];

endmodule

// File: tb/tb_bdc_root.sv
// Directed bench for bdc_root: SPI register access, watchdog trip/clear,
// tach counting and PWM duty/direction/overcurrent behaviour.
module tb_bdc_root;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tstn, wdogdisn;
  logic       cl0, cl1, cl2;
  logic [1:0] tach0, tach1, tach2;
  logic       motorena;
  logic [1:0] pwm0, pwm1, pwm2;

  int n_chk = 0;
  int n_err = 0;

  bdc_root_if spi ();

  bdc_root dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi           (spi.slave),
    .tstn          (tstn),
    .wdogdisn      (wdogdisn),
    .currentlimit0 (cl0),
    .currentlimit1 (cl1),
    .currentlimit2 (cl2),
    .tach0         (tach0),
    .tach1         (tach1),
    .tach2         (tach2),
    .motorena      (motorena),
    .pwm0          (pwm0),
    .pwm1          (pwm1),
    .pwm2          (pwm2)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] b1, input logic [7:0] b2, input int nbits,
                          output logic [7:0] rd);
    logic [15:0] tx;
    tx = {b1, b2};
    rd = '0;
    spi.ss = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 16 - nbits; i--) begin
      spi.sclk = 1'b0;
      spi.mosi = tx[i];
      repeat (4) @(negedge clk);
      if (i < 8) rd = {rd[6:0], spi.miso_pin};
      spi.sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    spi.ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] junk;
    spi_xfer({1'b0, a, 3'b000}, d, 16, junk);
  endtask

  task automatic spi_rd(input logic [3:0] a, output logic [7:0] d);
    spi_xfer({1'b1, a, 3'b000}, 8'h00, 16, d);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    spi_rd(a, d);
    chk(tag, {24'h0, d}, {24'h0, exp});
  endtask

  // High-cycle counts of pwm0[0] and pwm0[1] over one full 256-clk period.
  task automatic count_pwm0(output int c_fwd, output int c_rev);
    c_fwd = 0;
    c_rev = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm0[0]) c_fwd++;
      if (pwm0[1]) c_rev++;
    end
  endtask

  initial begin
    int         cf, cr;
    logic [7:0] junk;

    rstn     = 1'b0;
    spi.sclk = 1'b1;
    spi.ss   = 1'b0;
    spi.mosi = 1'b0;
    tstn     = 1'b0;
    wdogdisn = 1'b1;
    {cl0, cl1, cl2} = 3'b000;
    tach0 = 2'b00; tach1 = 2'b00; tach2 = 2'b00;
    repeat (5) @(negedge clk);
    chk("rst_motorena", {31'h0, motorena}, 32'h0);
    chk("rst_pwm", {26'h0, pwm2, pwm1, pwm0}, 32'h0);
    chk("rst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    rd_chk("hwcfg", 4'hD, 8'h30);
    rd_chk("rst_wddiv", 4'hE, 8'hFF);
    rd_chk("rst_wdctl", 4'hF, 8'h00);
    rd_chk("rst_duty0", 4'h0, 8'h00);
    chk("idle_miso_oe", {31'h0, spi.miso_oe}, 32'h0);

    spi_wr(4'h2, 8'h01);
    spi_wr(4'h6, 8'h02);
    spi_wr(4'hA, 8'h04);
    rd_chk("cfg0", 4'h2, 8'h01);
    rd_chk("cfg1", 4'h6, 8'h02);
    rd_chk("cfg2", 4'hA, 8'h04);
    rd_chk("reserved3", 4'h3, 8'h00);

    // A write cut short after 12 bits must be discarded.
    spi_xfer({1'b0, 4'hE, 3'b000}, 8'h55, 12, junk);
    rd_chk("abort_wddiv", 4'hE, 8'hFF);

    // Watchdog: 17 fast ticks of 64 clk = 1088 clk to trip.
    spi_wr(4'hE, 8'h10);
    spi_wr(4'hF, 8'h0F);
    repeat (1250) @(negedge clk);
    chk("wd_trip_motorena", {31'h0, motorena}, 32'h0);
    rd_chk("wd_trip_wdctl", 4'hF, 8'h8F);
    spi_wr(4'hF, 8'h80);
    spi_wr(4'hF, 8'h0F);
    rd_chk("wd_clear_wdctl", 4'hF, 8'h0F);
    chk("wd_clear_motorena", {31'h0, motorena}, 32'h1);

    spi_wr(4'hE, 8'h00);
    repeat (100) @(negedge clk);
    chk("wddiv0_motorena", {31'h0, motorena}, 32'h0);
    rd_chk("wddiv0_wdctl", 4'hF, 8'h8F);
    spi_wr(4'hF, 8'h80);

    wdogdisn = 1'b0;
    spi_wr(4'hF, 8'h0F);
    repeat (50000) @(negedge clk);
    rd_chk("wdogdis_wdctl", 4'hF, 8'h0F);
    chk("wdogdis_motorena", {31'h0, motorena}, 32'h1);

    // Tach channel 0: forward steps then one reverse and one illegal jump.
    tach0 = 2'b01; repeat (5) @(negedge clk);
    rd_chk("tach0_step1", 4'h1, 8'h01);
    tach0 = 2'b11; repeat (5) @(negedge clk);
    tach0 = 2'b10; repeat (5) @(negedge clk);
    tach0 = 2'b00; repeat (5) @(negedge clk);
    rd_chk("tach0_step4", 4'h1, 8'h04);
    tach0 = 2'b10; repeat (5) @(negedge clk);
    rd_chk("tach0_reverse", 4'h1, 8'h03);
    tach0 = 2'b01; repeat (5) @(negedge clk);
    rd_chk("tach0_double", 4'h1, 8'h03);
    tach2 = 2'b01; repeat (5) @(negedge clk);
    rd_chk("tach2_invert_wrap", 4'h9, 8'hFF);

    // PWM on channel 0; channel 1 is braked, channel 2 has zero duty.
    spi_wr(4'h2, 8'h00);
    spi_wr(4'h0, 8'h40);
    rd_chk("duty0_rb", 4'h0, 8'h40);
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("pwm_d40_fwd", cf, 64);
    chk("pwm_d40_rev", cr, 0);
    chk("brake_pwm1", {30'h0, pwm1}, 32'h3);
    chk("zero_pwm2", {30'h0, pwm2}, 32'h0);

    spi_wr(4'h0, 8'hC0);
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("pwm_dC0_fwd", cf, 192);

    spi_wr(4'h0, 8'hFF);
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("pwm_dFF_fwd", cf, 255);

    spi_wr(4'h0, 8'h80);
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("pwm_d80_fwd", cf, 128);
    chk("pwm_d80_rev", cr, 0);

    spi_wr(4'h2, 8'h01);
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("pwm_rev_fwd", cf, 0);
    chk("pwm_rev_rev", cr, 128);

    cl0 = 1'b1;
    repeat (4) @(negedge clk);
    count_pwm0(cf, cr);
    chk("oc_pwm0", cf + cr, 0);
    cl0 = 1'b0;
    repeat (300) @(negedge clk);
    count_pwm0(cf, cr);
    chk("oc_release_rev", cr, 128);

    spi_wr(4'hF, 8'h0E);
    repeat (3) @(negedge clk);
    chk("chen0_off_pwm0", {30'h0, pwm0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
